// File: rtl/region_redraw_engine.sv
// Redraws a screen-clipped dirty rectangle from the background ROM at one pixel per clock, then triggers the sprite overlay.
// Each plot trails its address by ROM_LAT cycles; abort cancels from any busy state and flushes pixels in flight.
module region_redraw_engine #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int ROM_LAT  = 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [X_W-1:0]     rect_x,
    input  logic [Y_W-1:0]     rect_y,
    input  logic [X_W-1:0]     rect_w,
    input  logic [Y_W-1:0]     rect_h,
    input  logic               abort,
    output logic [X_W-1:0]     bg_x,
    output logic [Y_W-1:0]     bg_y,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               plot,
    output logic [X_W-1:0]     plot_x,
    output logic [Y_W-1:0]     plot_y,
    output logic [COLOR_W-1:0] plot_color,
    output logic               char_start,
    input  logic               char_done,
    output logic               busy,
    output logic               done
);
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CHAR, CHAR_WAIT, DONE} state_t;

    localparam logic [X_W:0]   SCR_W      = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   SCR_H      = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W:0]   X_ONE_W    = (X_W+1)'(1);
    localparam logic [Y_W:0]   Y_ONE_W    = (Y_W+1)'(1);
    localparam logic [X_W-1:0] X_ONE      = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE      = Y_W'(1);
    localparam logic [2:0]     DRAIN_LAST = 3'(ROM_LAT - 1);

    state_t         state_q, state_d;
    logic [X_W-1:0] x_q, x_d, x_first_q, x_first_d, x_last_q, x_last_d;
    logic [Y_W-1:0] y_q, y_d, y_last_q, y_last_d;
    logic [2:0]     cnt_q, cnt_d;

    logic           pipe_vld_q [ROM_LAT];
    logic [X_W-1:0] pipe_x_q   [ROM_LAT];
    logic [Y_W-1:0] pipe_y_q   [ROM_LAT];

    logic [X_W:0]   x_sum, x_end, x_end_m1;
    logic [Y_W:0]   y_sum, y_end, y_end_m1;
    logic           empty;
    logic           flush;

    // Sums carry one extra bit so a wide rect near the right/bottom edge cannot wrap before clipping.
    always_comb begin
        x_sum    = {1'b0, rect_x} + {1'b0, rect_w};
        y_sum    = {1'b0, rect_y} + {1'b0, rect_h};
        x_end    = (x_sum > SCR_W) ? SCR_W : x_sum;
        y_end    = (y_sum > SCR_H) ? SCR_H : y_sum;
        x_end_m1 = x_end - X_ONE_W;
        y_end_m1 = y_end - Y_ONE_W;
        empty    = (rect_w == '0) || (rect_h == '0) ||
                   ({1'b0, rect_x} >= SCR_W) || ({1'b0, rect_y} >= SCR_H);
        flush    = abort && (state_q != IDLE);
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        x_first_d = x_first_q;
        x_last_d  = x_last_q;
        y_last_d  = y_last_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d       = rect_x;
                    y_d       = rect_y;
                    x_first_d = rect_x;
                    x_last_d  = x_end_m1[X_W-1:0];
                    y_last_d  = y_end_m1[Y_W-1:0];
                    state_d   = empty ? CHAR : SCAN;
                end
            end
            SCAN: begin
                if (x_q == x_last_q) begin
                    x_d = x_first_q;
                    if (y_q == y_last_q) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        y_d = y_q + Y_ONE;
                    end
                end else begin
                    x_d = x_q + X_ONE;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) state_d = CHAR;
                else                     cnt_d   = cnt_q + 3'd1;
            end
            CHAR:      state_d = CHAR_WAIT;
            CHAR_WAIT: if (char_done) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            x_first_q <= '0;
            x_last_q  <= '0;
            y_last_q  <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_x_q[i]   <= '0;
                pipe_y_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            x_first_q     <= x_first_d;
            x_last_q      <= x_last_d;
            y_last_q      <= y_last_d;
            cnt_q         <= cnt_d;
            pipe_vld_q[0] <= (state_q == SCAN) && !flush;
            pipe_x_q[0]   <= x_q;
            pipe_y_q[0]   <= y_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1] && !flush;
                pipe_x_q[i]   <= pipe_x_q[i-1];
                pipe_y_q[i]   <= pipe_y_q[i-1];
            end
        end
    end

    assign bg_x       = x_q;
    assign bg_y       = y_q;
    assign plot       = pipe_vld_q[ROM_LAT-1];
    assign plot_x     = pipe_x_q[ROM_LAT-1];
    assign plot_y     = pipe_y_q[ROM_LAT-1];
    // ROM data arrives in the same cycle as the delayed strobe, so colour is steered rather than re-registered.
    assign plot_color = plot ? bg_color : '0;
    assign char_start = (state_q == CHAR);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
endmodule

// File: tb/tb_region_redraw_engine.sv
// Directed bench for region_redraw_engine with a 2-cycle background ROM model.
module tb_region_redraw_engine;
    logic       clock = 1'b0, resetn = 1'b1, start = 1'b0, abort = 1'b0, char_done = 1'b0;
    logic [8:0] rect_x = '0, rect_w = '0;
    logic [7:0] rect_y = '0, rect_h = '0;
    logic [8:0] bg_x, plot_x;
    logic [7:0] bg_y, plot_y;
    logic [2:0] bg_color, plot_color;
    logic       plot, char_start, busy, done;
    logic [8:0] a1x = '0, a2x = '0;
    logic [7:0] a1y = '0, a2y = '0;

    region_redraw_engine #(.X_W(9), .Y_W(8), .COLOR_W(3), .SCREEN_W(320), .SCREEN_H(240), .ROM_LAT(2)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .abort(abort), .bg_x(bg_x), .bg_y(bg_y), .bg_color(bg_color),
        .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color),
        .char_start(char_start), .char_done(char_done), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] rom(input logic [8:0] x, input logic [7:0] y);
        return x[2:0] ^ y[2:0] ^ {y[3], x[4], x[3]};
    endfunction

    always @(posedge clock) begin
        a1x <= bg_x; a1y <= bg_y;
        a2x <= a1x;  a2y <= a1y;
    end
    assign bg_color = rom(a2x, a2y);

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic       mon_clr = 1'b0;
    int         plot_cnt = 0, first_cyc = 0, last_cyc = 0, gaps = 0, col_err = 0, oob = 0;
    int         cs_cnt = 0, cs_cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0;
    logic [8:0] first_x = '0, last_x = '0;
    logic [7:0] first_y = '0, last_y = '0;

    always @(negedge clock) begin
        if (mon_clr) begin
            plot_cnt <= 0; gaps <= 0; col_err <= 0; oob <= 0;
            cs_cnt <= 0; done_cnt <= 0; busy_cnt <= 0;
        end else begin
            if (plot) begin
                if (plot_cnt == 0) begin
                    first_x <= plot_x; first_y <= plot_y; first_cyc <= cyc;
                end else if (cyc != last_cyc + 1) begin
                    gaps <= gaps + 1;
                end
                last_x <= plot_x; last_y <= plot_y; last_cyc <= cyc;
                if (plot_color !== rom(plot_x, plot_y)) col_err <= col_err + 1;
                if (plot_x >= 9'd320 || plot_y >= 8'd240) oob <= oob + 1;
                plot_cnt <= plot_cnt + 1;
            end
            if (char_start) begin cs_cnt <= cs_cnt + 1; cs_cyc <= cyc; end
            if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    int n_chk = 0, n_fail = 0;
    int st_cyc = 0, cd_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic begin_op(input int rx, input int ry, input int rw, input int rh);
        rect_x = 9'(rx); rect_y = 8'(ry); rect_w = 9'(rw); rect_h = 8'(rh);
        start = 1'b1; mon_clr = 1'b1; st_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic finish_op(input string tag);
        int i;
        i = 0;
        while (cs_cnt == 0 && i < 80000) begin @(posedge clock); #1; i++; end
        if (cs_cnt == 0) begin
            chk({tag, "_char_start_timeout"}, cs_cnt, 1);
        end else begin
            while (cyc < cs_cyc + 5) begin @(posedge clock); #1; end
            char_done = 1'b1; cd_cyc = cyc;
            @(posedge clock); #1;
            char_done = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    typedef struct { int rx, ry, rw, rh, n, fx, fy, lx, ly; } vec_t;
    vec_t vecs[10];

    initial begin
        vecs[0] = '{10, 20, 4, 2, 8, 10, 20, 13, 21};
        vecs[1] = '{316, 238, 10, 10, 8, 316, 238, 319, 239};
        vecs[2] = '{0, 0, 0, 5, 0, 0, 0, 0, 0};
        vecs[3] = '{400, 0, 5, 5, 0, 0, 0, 0, 0};
        vecs[4] = '{5, 239, 3, 1, 3, 5, 239, 7, 239};
        vecs[5] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
        vecs[6] = '{319, 0, 1, 3, 3, 319, 0, 319, 2};
        vecs[7] = '{300, 10, 511, 1, 20, 300, 10, 319, 10};
        vecs[8] = '{0, 230, 2, 255, 20, 0, 230, 1, 239};
        vecs[9] = '{0, 0, 320, 240, 76800, 0, 0, 319, 239};

        #1 resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_char_start", int'(char_start), 0);
        chk("rst_bg_xy", int'({bg_x, bg_y}), 0);
        chk("rst_plot_xyc", int'({plot_x, plot_y, plot_color}), 0);
        resetn = 1'b1;
        @(posedge clock); #1;

        for (int v = 0; v < 10; v++) begin
            begin_op(vecs[v].rx, vecs[v].ry, vecs[v].rw, vecs[v].rh);
            finish_op($sformatf("v%0d", v));
            chk($sformatf("v%0d_plots", v), plot_cnt, vecs[v].n);
            if (vecs[v].n > 0) begin
                chk($sformatf("v%0d_first_xy", v), int'({first_x, first_y}), int'({9'(vecs[v].fx), 8'(vecs[v].fy)}));
                chk($sformatf("v%0d_last_xy", v), int'({last_x, last_y}), int'({9'(vecs[v].lx), 8'(vecs[v].ly)}));
                chk($sformatf("v%0d_first_cyc", v), first_cyc, st_cyc + 3);
                chk($sformatf("v%0d_last_cyc", v), last_cyc, st_cyc + 2 + vecs[v].n);
            end
            chk($sformatf("v%0d_gaps", v), gaps, 0);
            chk($sformatf("v%0d_colour_err", v), col_err, 0);
            chk($sformatf("v%0d_out_of_screen", v), oob, 0);
            chk($sformatf("v%0d_char_start_cyc", v), cs_cyc, (vecs[v].n > 0) ? st_cyc + 3 + vecs[v].n : st_cyc + 1);
            chk($sformatf("v%0d_char_start_cnt", v), cs_cnt, 1);
            chk($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            chk($sformatf("v%0d_done_cyc", v), done_cyc, cd_cyc + 1);
            chk($sformatf("v%0d_busy_cycles", v), busy_cnt, cd_cyc + 1 - st_cyc);
            chk($sformatf("v%0d_busy_after", v), int'(busy), 0);
        end

        // start pulsed mid-SCAN with a different rect must be ignored
        fork
            begin
                begin_op(10, 20, 4, 2);
                finish_op("busy_start");
            end
            begin
                repeat (3) @(posedge clock);
                #2;
                start = 1'b1; rect_x = 9'd100; rect_y = 8'd100; rect_w = 9'd50; rect_h = 8'd50;
                @(posedge clock); #2;
                start = 1'b0;
            end
        join
        chk("busy_start_plots", plot_cnt, 8);
        chk("busy_start_last_xy", int'({last_x, last_y}), int'({9'd13, 8'd21}));
        chk("busy_start_done_cnt", done_cnt, 1);
        repeat (3) @(posedge clock);
        #1;
        chk("busy_start_idle", int'(busy), 0);

        // abort in the 5th SCAN cycle
        begin_op(10, 20, 4, 2);
        repeat (4) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("abort_busy_next", int'(busy), 0);
        repeat (10) @(posedge clock);
        #1;
        chk("abort_plots", plot_cnt, 3);
        chk("abort_last_plot_cyc", last_cyc, st_cyc + 5);
        chk("abort_char_start", cs_cnt, 0);
        chk("abort_done", done_cnt, 0);
        begin_op(0, 0, 2, 2);
        finish_op("post_abort");
        chk("post_abort_plots", plot_cnt, 4);
        chk("post_abort_done", done_cnt, 1);

        // reset mid-SCAN, with char_done held across the release
        begin_op(0, 0, 50, 50);
        repeat (6) @(posedge clock);
        #1;
        resetn = 1'b0;
        char_done = 1'b1;
        #1;
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_bg_xy", int'({bg_x, bg_y}), 0);
        chk("midrst_plot_xyc", int'({plot_x, plot_y, plot_color}), 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        char_done = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("midrst_idle", int'(busy), 0);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_no_char_start", cs_cnt, 0);
        begin_op(3, 4, 1, 1);
        finish_op("post_rst");
        chk("post_rst_plots", plot_cnt, 1);
        chk("post_rst_xy", int'({last_x, last_y}), int'({9'd3, 8'd4}));
        chk("post_rst_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
